move_ctrl_sequencer: RTL

- Moore control-step sequencer that drives the CPU datapath strobes for instruction fetch and the special-register move class: mfhi, mflo, in, out.
- Replaces hand-sequenced T0..Tn strobes with a reusable, parametrised unit.
- Adds four things:
  - memory-ready stall in the read step;
  - stall timeout;
  - sticky fault state for illegal opcodes;
  - a completed-instruction counter.
- Sits between the IR/memory interface and the control inputs of the datapath.

---
 rtl/move_ctrl_sequencer_if.sv | 47 ++++
 rtl/move_ctrl_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/move_ctrl_sequencer_if.sv
// Bundle between the IR/memory side and the datapath control inputs.
// The sequencer uses the slave modport; whoever drives run/ir/mem_rdy uses master.
interface move_ctrl_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [31:0]      ir;
  logic             mem_rdy;

  logic             PCout;
  logic             MARin;
  logic             IncPC;
  logic             Zin;
  logic             ZLOout;
  logic             PCin;
  logic             MDRread;
  logic             MDRin;
  logic             MDRout;
  logic             IRin;

  logic             HIout;
  logic             LOout;
  logic             InPortout;
  logic             OPin;
  logic             Gra;
  logic             Rin;
  logic             Rout;

  logic [2:0]       step;
  logic             busy;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output run, ir, mem_rdy,
    input  PCout, MARin, IncPC, Zin, ZLOout, PCin, MDRread, MDRin, MDRout, IRin,
    input  HIout, LOout, InPortout, OPin, Gra, Rin, Rout,
    input  step, busy, fault_code, instr_count
  );

  modport slave (
    input  run, ir, mem_rdy,
    output PCout, MARin, IncPC, Zin, ZLOout, PCin, MDRread, MDRin, MDRout, IRin,
    output HIout, LOout, InPortout, OPin, Gra, Rin, Rout,
    output step, busy, fault_code, instr_count
  );
endinterface

// File: rtl/move_ctrl_sequencer.sv
// Moore T0..T4 control-step sequencer for fetch plus mfhi/mflo/in/out, with a
// memory-ready stall in T2, stall timeout, sticky fault state and a retire counter.
module move_ctrl_sequencer #(
  parameter int         CNT_W       = 16,
  parameter int         MEM_TIMEOUT = 15,
  parameter logic [4:0] OP_MFHI     = 5'b11000,
  parameter logic [4:0] OP_MFLO     = 5'b11001,
  parameter logic [4:0] OP_IN       = 5'b10110,
  parameter logic [4:0] OP_OUT      = 5'b10111
) (
  input  logic                  clk,
  input  logic                  clr,
  move_ctrl_sequencer_if.slave  bus
);

  localparam int STALL_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_T0    = 3'd1,
    S_T1    = 3'd2,
    S_T2    = 3'd3,
    S_T3    = 3'd4,
    S_T4    = 3'd5,
    S_FAULT = 3'd7
  } state_t;

  state_t             state_reg,  state_next;
  logic [STALL_W-1:0] stall_reg,  stall_next;
  logic [1:0]         fault_reg,  fault_next;
  logic [CNT_W-1:0]   count_reg,  count_next;

  logic [4:0] opcode;
  logic       is_mfhi, is_mflo, is_in, is_out, is_legal;
  logic       ir_unused;

  assign opcode    = bus.ir[31:27];
  assign is_mfhi   = (opcode == OP_MFHI);
  assign is_mflo   = (opcode == OP_MFLO);
  assign is_in     = (opcode == OP_IN);
  assign is_out    = (opcode == OP_OUT);
  assign is_legal  = is_mfhi | is_mflo | is_in | is_out;
  assign ir_unused = ^bus.ir[26:0];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= S_IDLE;
      stall_reg <= '0;
      fault_reg <= 2'b00;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      stall_reg <= stall_next;
      fault_reg <= fault_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stall_next = stall_reg;
    fault_next = fault_reg;
    count_next = count_reg;
    case (state_reg)
      S_IDLE: if (bus.run) state_next = S_T0;
      S_T0:   state_next = S_T1;
      S_T1: begin
        state_next = S_T2;
        stall_next = '0;
      end
      S_T2: begin
        if (bus.mem_rdy) begin
          state_next = S_T3;
        end else if (stall_reg == STALL_LAST) begin
          state_next = S_FAULT;
          fault_next = 2'b10;
        end else begin
          stall_next = stall_reg + STALL_W'(1);
        end
      end
      S_T3:   state_next = S_T4;
      S_T4: begin
        if (!is_legal) begin
          state_next = S_FAULT;
          fault_next = 2'b01;
        end else begin
          count_next = count_reg + CNT_W'(1);
          state_next = bus.run ? S_T0 : S_IDLE;
        end
      end
      // Sticky until clr; run is deliberately ignored here.
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

  // Strobes are pure Moore decodes of the current step (and the opcode in T4).
  always_comb begin
    bus.PCout     = 1'b0;
    bus.MARin     = 1'b0;
    bus.IncPC     = 1'b0;
    bus.Zin       = 1'b0;
    bus.ZLOout    = 1'b0;
    bus.PCin      = 1'b0;
    bus.MDRread   = 1'b0;
    bus.MDRin     = 1'b0;
    bus.MDRout    = 1'b0;
    bus.IRin      = 1'b0;
    bus.HIout     = 1'b0;
    bus.LOout     = 1'b0;
    bus.InPortout = 1'b0;
    bus.OPin      = 1'b0;
    bus.Gra       = 1'b0;
    bus.Rin       = 1'b0;
    bus.Rout      = 1'b0;
    case (state_reg)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.ZLOout = 1'b1;
        bus.PCin   = 1'b1;
      end
      S_T2: begin
        bus.MDRread = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T3: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T4: begin
        bus.HIout     = is_mfhi;
        bus.LOout     = is_mflo;
        bus.InPortout = is_in;
        bus.OPin      = is_out;
        bus.Rout      = is_out;
        bus.Rin       = is_mfhi | is_mflo | is_in;
        bus.Gra       = is_legal;
      end
      default: ;
    endcase
  end

  assign bus.step        = state_reg;
  assign bus.busy        = (state_reg != S_IDLE) && (state_reg != S_FAULT);
  assign bus.fault_code  = fault_reg;
  assign bus.instr_count = count_reg;

endmodule
